srt_radix4_divider: RTL

//  Sequential unsigned radix-4 SRT divider; consumer of the digit-multiple (q*D, q in -2..2) datapath.

---
 rtl/srt_pkg.sv | 22 ++
 rtl/srt_qsel.sv | 42 ++++
 rtl/srt_radix4_divider.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/srt_pkg.sv
// srt_pkg: shared types and sizing helpers for the radix-4 SRT divider.
//   state_t   - divider FSM states
//   digit_t   - signed quotient digit, range -DIGIT_MAX..DIGIT_MAX
//   srt_n()   - number of digit iterations for operand width w
//   srt_rw()  - partial remainder width for operand width w
package srt_pkg;

    typedef enum logic [1:0] {IDLE, NORM, ITER, FIX} state_t;

    typedef logic signed [2:0] digit_t;

    localparam int DIGIT_MAX = 2;

    function automatic int unsigned srt_n(input int unsigned w);
        return w / 2 + 1;
    endfunction

    function automatic int unsigned srt_rw(input int unsigned w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/srt_qsel.sv
// srt_qsel: combinational radix-4 quotient digit selection.
//   r   in   RW   signed partial remainder
//   dn  in   W    normalized divisor (MSB set)
//   j   in   JW   digit position; thresholds scale by 4^j
//   q   out  3    selected digit in -2..2
// Thresholds Dn*4^j/2 and 3*Dn*4^j/2 are compared exactly by doubling R,
// which keeps the half-integer threshold at j=0 exact.
module srt_qsel
    import srt_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned RW = 2 * W + 4,
    parameter int unsigned JW = 3
) (
    input  logic signed [RW-1:0] r,
    input  logic        [W-1:0]  dn,
    input  logic        [JW-1:0] j,
    output digit_t               q
);

    logic signed [RW+1:0] r2;
    logic signed [RW+1:0] t1;
    logic signed [RW+1:0] t3;

    always_comb begin
        r2 = {r[RW-1], r, 1'b0};
        t1 = $signed({{(RW + 2 - W){1'b0}}, dn} << {j, 1'b0});
        t3 = t1 + (t1 <<< 1);
        if (r2 >= t3) begin
            q = digit_t'(DIGIT_MAX);
        end else if (r2 >= t1) begin
            q = digit_t'(1);
        end else if (r2 >= -t1) begin
            q = '0;
        end else if (r2 >= -t3) begin
            q = -digit_t'(1);
        end else begin
            q = -digit_t'(DIGIT_MAX);
        end
    end

endmodule

// File: rtl/srt_radix4_divider.sv
// srt_radix4_divider: sequential unsigned radix-4 SRT divider, one division in flight.
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   start        in   1   request, sampled only in IDLE
//   dividend     in   W   unsigned X, captured on accept
//   divisor      in   W   unsigned D, captured on accept
//   busy         out  1   FSM not in IDLE
//   done         out  1   one-cycle pulse, results valid
//   quotient     out  W   floor(X/D); all-ones when D==0
//   remainder    out  W   X mod D; X when D==0
//   div_by_zero  out  1   D==0 for the current result
// Optional: define SRT_INVARIANT_CHECK_EN to compile simulation-only invariant
// assertions on the partial remainder and the Q/QM registers.
module srt_radix4_divider
    import srt_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned N   = srt_n(W);
    localparam int unsigned RW  = srt_rw(W);
    localparam int unsigned QW  = W + 3;
    localparam int unsigned LZW = $clog2(W);
    localparam int unsigned JW  = $clog2(N);

    state_t               state_q, state_d;
    logic [W-1:0]         x_q, d_q, dn_q;
    logic [LZW-1:0]       lz_q;
    logic signed [RW-1:0] r_q;
    logic [QW-1:0]        q_q, qm_q;
    logic [JW-1:0]        j_q;
    logic                 dz_q;

    // Normalizer
    logic [LZW-1:0]       lz;
    logic                 found;
    logic [W-1:0]         dn_norm;
    logic [RW-1:0]        x_ext;
    logic signed [RW-1:0] r_norm;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found) begin
                if (d_q[W-1-i]) found = 1'b1;
                else            lz    = lz + LZW'(1);
            end
        end
        dn_norm = d_q << lz;
        x_ext   = RW'(x_q);
        r_norm  = $signed(x_ext << lz);
    end

    // Digit selection and remainder update
    digit_t               digit;
    logic signed [2*W-1:0] dn_ext, mult;
    logic signed [RW-1:0] mult_rw, r_next;

    srt_qsel #(
        .W  (W),
        .RW (RW),
        .JW (JW)
    ) u_qsel (
        .r  (r_q),
        .dn (dn_q),
        .j  (j_q),
        .q  (digit)
    );

    always_comb begin
        dn_ext = $signed({{W{1'b0}}, dn_q});
        case (digit)
            3'sd2:   mult = dn_ext <<< 1;
            3'sd1:   mult = dn_ext;
            -3'sd1:  mult = -dn_ext;
            -3'sd2:  mult = -(dn_ext <<< 1);
            default: mult = '0;
        endcase
        mult_rw = {{(RW - 2 * W){mult[2*W-1]}}, mult};
        r_next  = r_q - (mult_rw <<< {j_q, 1'b0});
    end

    // On-the-fly conversion: Q holds the quotient, QM holds Q-1
    logic [QW-1:0] dq, q_next, qm_next;

    always_comb begin
        dq = {{(QW - 3){digit[2]}}, digit};
        if (!digit[2]) q_next = (q_q << 2) + dq;
        else           q_next = (qm_q << 2) + dq + QW'(4);
        if (digit[2] || digit == '0) qm_next = (qm_q << 2) + dq + QW'(3);
        else                         qm_next = (q_q << 2) + dq - QW'(1);
    end

    // Final correction: a negative remainder means Q overshot by one
    logic [RW-1:0] dn_rw, fix_val, fix_rem;

    always_comb begin
        dn_rw   = RW'(dn_q);
        fix_val = r_q[RW-1] ? $unsigned(r_q) + dn_rw : $unsigned(r_q);
        fix_rem = fix_val >> lz_q;
    end

    // FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = NORM;
            NORM:    state_d = (d_q == '0) ? FIX : ITER;
            ITER:    if (j_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            d_q         <= '0;
            dn_q        <= '0;
            lz_q        <= '0;
            r_q         <= '0;
            q_q         <= '0;
            qm_q        <= '0;
            j_q         <= '0;
            dz_q        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q <= dividend;
                        d_q <= divisor;
                    end
                end
                NORM: begin
                    dn_q <= dn_norm;
                    lz_q <= lz;
                    r_q  <= r_norm;
                    q_q  <= '0;
                    qm_q <= '0;
                    dz_q <= (d_q == '0);
                    j_q  <= JW'(N - 1);
                end
                ITER: begin
                    r_q  <= r_next;
                    q_q  <= q_next;
                    qm_q <= qm_next;
                    j_q  <= j_q - JW'(1);
                end
                FIX: begin
                    div_by_zero <= dz_q;
                    if (dz_q) begin
                        quotient  <= '1;
                        remainder <= x_q;
                    end else begin
                        quotient  <= r_q[RW-1] ? W'(qm_q) : W'(q_q);
                        remainder <= W'(fix_rem);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRT_INVARIANT_CHECK_EN
    logic [RW-1:0] chk_abs;
    logic [RW+2:0] chk_abs3, chk_bound;

    always_comb begin
        chk_abs   = r_next[RW-1] ? $unsigned(-r_next) : $unsigned(r_next);
        chk_abs3  = (RW + 3)'(chk_abs) * (RW + 3)'(3);
        chk_bound = ((RW + 3)'(dn_q) << {j_q, 1'b0}) << 1;
    end

    always @(posedge clk) begin
        if (!rst && state_q == ITER) begin
            assert (chk_abs3 <= chk_bound)
                else $error("srt: |R| bound violated at j=%0d", j_q);
        end
        if (!rst && state_q == FIX && !dz_q) begin
            assert (q_q - qm_q == QW'(1))
                else $error("srt: Q-QM != 1");
            assert (fix_rem < RW'(d_q))
                else $error("srt: remainder %0d not below divisor %0d", fix_rem, d_q);
        end
    end
`endif

endmodule
